// File: rtl/bank_linefill_ctrl_if.sv
// Bundle of HTU request, BIU read, linefill buffer, completion and release signals
// for one bank's linefill controller. Signal names keep the controller's port names.
interface bank_linefill_ctrl_if #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 32
);
  logic              lf_req_valid_i;
  logic              lf_req_ready_o;
  logic [IDX_W-1:0]  lf_req_idx_i;
  logic [ADDR_W-1:0] lf_req_addr_i;
  logic              biu_ar_valid_o;
  logic              biu_ar_ready_i;
  logic [IDX_W-1:0]  biu_ar_id_o;
  logic [ADDR_W-1:0] biu_ar_addr_o;
  logic              biu_r_valid_i;
  logic [IDX_W-1:0]  biu_r_id_i;
  logic [127:0]      biu_r_data_i;
  logic              lfb_wen_o;
  logic [IDX_W-1:0]  lfb_waddr_o;
  logic              lfb_wbeat_o;
  logic [127:0]      lfb_wdata_o;
  logic              biu_isu_rvalid_o;
  logic [IDX_W-1:0]  biu_isu_rid_o;
  logic              lf_rel_valid_i;
  logic [IDX_W-1:0]  lf_rel_idx_i;
  logic [IDX_W:0]    inflight_cnt_o;
  logic              err_o;

  // Controller side
  modport master (
    input  lf_req_valid_i, lf_req_idx_i, lf_req_addr_i,
    input  biu_ar_ready_i, biu_r_valid_i, biu_r_id_i, biu_r_data_i,
    input  lf_rel_valid_i, lf_rel_idx_i,
    output lf_req_ready_o, biu_ar_valid_o, biu_ar_id_o, biu_ar_addr_o,
    output lfb_wen_o, lfb_waddr_o, lfb_wbeat_o, lfb_wdata_o,
    output biu_isu_rvalid_o, biu_isu_rid_o, inflight_cnt_o, err_o
  );

  // Environment side (HTU, BIU, issue queue, buffer)
  modport slave (
    output lf_req_valid_i, lf_req_idx_i, lf_req_addr_i,
    output biu_ar_ready_i, biu_r_valid_i, biu_r_id_i, biu_r_data_i,
    output lf_rel_valid_i, lf_rel_idx_i,
    input  lf_req_ready_o, biu_ar_valid_o, biu_ar_id_o, biu_ar_addr_o,
    input  lfb_wen_o, lfb_waddr_o, lfb_wbeat_o, lfb_wdata_o,
    input  biu_isu_rvalid_o, biu_isu_rid_o, inflight_cnt_o, err_o
  );
endinterface

// File: rtl/bank_linefill_ctrl.sv
// Per-bank linefill (MSHR) controller: one slot per set/way index, one BIU read
// per slot, two-beat fill into the linefill buffer, completion pulse, release.
module bank_linefill_ctrl #(
  parameter int IDX_W   = 6,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  bank_linefill_ctrl_if.master bus
);
  localparam int SLOTS = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_DONE} slot_e;

  slot_e             r_state     [SLOTS];
  slot_e             w_state_nxt [SLOTS];
  logic [SLOTS-1:0]  r_beat;
  logic [SLOTS-1:0]  w_beat_nxt;
  logic [ADDR_W-1:0] r_addr      [SLOTS];
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_ar_valid;
  logic [IDX_W-1:0]  r_ar_id;
  logic [ADDR_W-1:0] r_ar_addr;
  logic              r_isu_valid;
  logic [IDX_W-1:0]  r_isu_rid;
  logic [IDX_W:0]    r_cnt;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_ar_load_en;
  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_r_hit;
  logic              w_r_last;
  logic              w_rel_ok;
  logic              w_err_set;

  assign w_ready      = (r_state[bus.lf_req_idx_i] == S_IDLE) && (r_cnt < (IDX_W+1)'(MAX_OUT));
  assign w_accept     = bus.lf_req_valid_i && w_ready;
  assign w_ar_load_en = !r_ar_valid || bus.biu_ar_ready_i;
  assign w_r_hit      = bus.biu_r_valid_i && (r_state[bus.biu_r_id_i] == S_WAIT);
  assign w_r_last     = w_r_hit && r_beat[bus.biu_r_id_i];
  assign w_rel_ok     = bus.lf_rel_valid_i && (r_state[bus.lf_rel_idx_i] == S_DONE);
  assign w_err_set    = (bus.biu_r_valid_i && !w_r_hit) || (bus.lf_rel_valid_i && !w_rel_ok);

  // Round-robin pick: lowest PEND slot at or above rr_ptr, wrapping to 0
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      cand = r_rr_ptr + IDX_W'(k);
      if (!w_sel_found && r_state[cand] == S_PEND) begin
        w_sel_found = 1'b1;
        w_sel_idx   = cand;
      end
    end
  end

  // Per-slot next state; accept/load/beat/release each need a distinct current state,
  // so at most one of them touches any given slot in a cycle
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    if (w_ar_load_en && w_sel_found) w_state_nxt[w_sel_idx] = S_WAIT;
    if (w_r_hit) begin
      w_beat_nxt[bus.biu_r_id_i] = ~r_beat[bus.biu_r_id_i];
      if (w_r_last) w_state_nxt[bus.biu_r_id_i] = S_DONE;
    end
    if (w_accept) begin
      w_state_nxt[bus.lf_req_idx_i] = S_PEND;
      w_beat_nxt[bus.lf_req_idx_i]  = 1'b0;
    end
    if (w_rel_ok) w_state_nxt[bus.lf_rel_idx_i] = S_IDLE;
  end

  // Slot state and beat registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SLOTS; s++) r_state[s] <= S_IDLE;
      r_beat <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Line address captured per slot on accept
  always_ff @(posedge clk_i) begin
    if (w_accept) r_addr[bus.lf_req_idx_i] <= bus.lf_req_addr_i;
  end

  // AR register, round-robin pointer, completion pulse, inflight count, sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ar_valid  <= 1'b0;
      r_ar_id     <= '0;
      r_ar_addr   <= '0;
      r_rr_ptr    <= '0;
      r_isu_valid <= 1'b0;
      r_isu_rid   <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_ar_load_en) begin
        if (w_sel_found) begin
          r_ar_valid <= 1'b1;
          r_ar_id    <= w_sel_idx;
          r_ar_addr  <= r_addr[w_sel_idx];
          r_rr_ptr   <= w_sel_idx + IDX_W'(1);
        end else begin
          r_ar_valid <= 1'b0;
        end
      end
      r_isu_valid <= w_r_last;
      if (w_r_last) r_isu_rid <= bus.biu_r_id_i;
      case ({w_accept, w_r_last})
        2'b10:   r_cnt <= r_cnt + (IDX_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (IDX_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.lf_req_ready_o   = w_ready;
  assign bus.biu_ar_valid_o   = r_ar_valid;
  assign bus.biu_ar_id_o      = r_ar_id;
  assign bus.biu_ar_addr_o    = r_ar_addr;
  assign bus.lfb_wen_o        = w_r_hit;
  assign bus.lfb_waddr_o      = bus.biu_r_id_i;
  assign bus.lfb_wbeat_o      = r_beat[bus.biu_r_id_i];
  assign bus.lfb_wdata_o      = bus.biu_r_data_i;
  assign bus.biu_isu_rvalid_o = r_isu_valid;
  assign bus.biu_isu_rid_o    = r_isu_rid;
  assign bus.inflight_cnt_o   = r_cnt;
  assign bus.err_o            = r_err;
endmodule
